// File: rtl/iob_clint_mh_pkg.sv
// Shared constants for the multi-hart CLINT: register offsets, CTRL field
// positions, timer width, mtimecmp reset value and a byte-lane merge helper.
package iob_clint_mh_pkg;

   localparam int unsigned MTIME_W        = 64;

   localparam int unsigned MSIP_BASE      = 0;
   localparam int unsigned MTIMECMP_BASE  = 16384;
   localparam int unsigned CTRL_ADDR      = 49136;
   localparam int unsigned MTIME_BASE     = 49144;

   localparam int unsigned CTRL_EN_BIT    = 0;
   localparam int unsigned CTRL_SRC_BIT   = 1;
   localparam int unsigned CTRL_PRESC_LSB = 16;
   localparam int unsigned PRESC_W        = 16;

   localparam logic [MTIME_W-1:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

   // Replace only the byte lanes enabled in strb.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/iob_clint_mh_if.sv
// Native iob request/response bundle.
//   valid/address/wdata/wstrb : request, driven by the master
//   rdata/ready               : one-cycle response, driven by the slave
interface iob_clint_mh_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);
   logic                valid;
   logic [ADDR_W-1:0]   address;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic [DATA_W-1:0]   rdata;
   logic                ready;

   modport master (output valid, address, wdata, wstrb, input rdata, ready);
   modport slave  (input valid, address, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/iob_clint_mh_tick.sv
// Time-base generator for mtime.
//   clk, rst_n  : system clock, async active-low reset
//   rtc         : external real-time clock, asynchronous to clk
//   src         : 0 = synchronised rtc rising edge, 1 = prescaler
//   presc       : prescaler divide value (tick every presc+1 cycles)
//   reload      : CTRL write strobe, restarts the prescaler from reload_val
//   tick        : one-cycle increment request
module iob_clint_mh_tick
   import iob_clint_mh_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               rtc,
   input  logic               src,
   input  logic [PRESC_W-1:0] presc,
   input  logic               reload,
   input  logic [PRESC_W-1:0] reload_val,
   output logic               tick
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   sync_d;
   logic                   rtc_tick;
   logic                   src_q;
   logic [PRESC_W-1:0]     cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync     <= '0;
         sync_d   <= 1'b0;
         rtc_tick <= 1'b0;
         src_q    <= 1'b0;
         cnt      <= '0;
      end else begin
         src_q <= src;
         if (src != src_q) begin
            // Saturate the edge detector so an edge already in the chain is lost.
            sync     <= '1;
            sync_d   <= 1'b1;
            rtc_tick <= 1'b0;
         end else begin
            sync     <= {sync[SYNC_STAGES-2:0], rtc};
            sync_d   <= sync[SYNC_STAGES-1];
            rtc_tick <= sync[SYNC_STAGES-1] & ~sync_d;
         end

         if (reload)          cnt <= reload_val;
         else if (cnt == '0)  cnt <= presc;
         else                 cnt <= cnt - 1'b1;
      end
   end

   // src_q lags src by one cycle; masking on it drops an rtc pulse that was
   // registered just before a switch back to rtc.
   assign tick = src ? (cnt == '0) : (rtc_tick & ~src_q);

endmodule

// File: rtl/iob_clint_mh.sv
// Multi-hart core-local interruptor on the iob bus.
//   clk, rst_n : system clock, async active-low reset
//   rtc        : external real-time clock (time base when CTRL.SRC=0)
//   bus        : iob slave port (valid/address/wdata/wstrb -> rdata/ready)
//   mtip       : per-hart timer interrupt, registered mtime >= mtimecmp[h]
//   msip       : per-hart software interrupt, MSIP[h].bit0
module iob_clint_mh
   import iob_clint_mh_pkg::*;
#(
   parameter int              N_HARTS     = 2,
   parameter int              ADDR_W      = 16,
   parameter int              DATA_W      = 32,
   parameter int              SYNC_STAGES = 2,
   parameter logic [PRESC_W-1:0] PRESC_RST = 16'd0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               rtc,
   iob_clint_mh_if.slave      bus,
   output logic [N_HARTS-1:0] mtip,
   output logic [N_HARTS-1:0] msip
);

   localparam int HIDX_W = (N_HARTS > 1) ? $clog2(N_HARTS) : 1;

   logic [MTIME_W-1:0] mtime;
   logic [MTIME_W-1:0] mtimecmp [N_HARTS];
   logic [31:0]        shadow;
   logic               en;
   logic               src;
   logic [PRESC_W-1:0] presc;
   logic               ready_r;
   logic [DATA_W-1:0]  rdata_r;
   logic               tick;

   logic [31:0]        addr;
   logic [31:0]        cmp_off;
   logic [HIDX_W-1:0]  msip_idx;
   logic [HIDX_W-1:0]  cmp_idx;
   logic               cmp_hi;
   logic               sel_msip, sel_cmp, sel_ctrl, sel_mtl, sel_mth;
   logic               wr, rd, ctrl_wr;
   logic [31:0]        ctrl_word;
   logic [31:0]        ctrl_new;
   logic [DATA_W-1:0]  rd_val;
   logic [31:0]        wr_val;

   always_comb begin
      addr     = 32'(bus.address);
      cmp_off  = addr - MTIMECMP_BASE;
      msip_idx = HIDX_W'((addr - MSIP_BASE) >> 2);
      cmp_idx  = HIDX_W'(cmp_off >> 3);
      cmp_hi   = cmp_off[2];
      sel_msip = (addr - MSIP_BASE) < 32'(4 * N_HARTS);
      sel_cmp  = cmp_off < 32'(8 * N_HARTS);
      sel_ctrl = addr == CTRL_ADDR;
      sel_mtl  = addr == MTIME_BASE;
      sel_mth  = addr == MTIME_BASE + 4;
      wr       = bus.valid & (|bus.wstrb);
      rd       = bus.valid & ~(|bus.wstrb);
      ctrl_wr  = wr & sel_ctrl;

      ctrl_word = '0;
      ctrl_word[CTRL_EN_BIT]  = en;
      ctrl_word[CTRL_SRC_BIT] = src;
      ctrl_word[CTRL_PRESC_LSB +: PRESC_W] = presc;
      ctrl_new  = merge_bytes(ctrl_word, bus.wdata, bus.wstrb);

      rd_val = '0;
      wr_val = '0;
      if (sel_msip) begin
         rd_val = {31'b0, msip[msip_idx]};
      end else if (sel_cmp) begin
         rd_val = cmp_hi ? mtimecmp[cmp_idx][63:32] : mtimecmp[cmp_idx][31:0];
         wr_val = merge_bytes(rd_val, bus.wdata, bus.wstrb);
      end else if (sel_ctrl) begin
         rd_val = ctrl_word;
      end else if (sel_mtl) begin
         rd_val = mtime[31:0];
         wr_val = merge_bytes(mtime[31:0], bus.wdata, bus.wstrb);
      end else if (sel_mth) begin
         rd_val = shadow;
         wr_val = merge_bytes(mtime[63:32], bus.wdata, bus.wstrb);
      end
   end

   iob_clint_mh_tick #(.SYNC_STAGES(SYNC_STAGES)) u_tick (
      .clk        (clk),
      .rst_n      (rst_n),
      .rtc        (rtc),
      .src        (src),
      .presc      (presc),
      .reload     (ctrl_wr),
      .reload_val (ctrl_new[CTRL_PRESC_LSB +: PRESC_W]),
      .tick       (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mtime   <= '0;
         shadow  <= '0;
         en      <= 1'b1;
         src     <= 1'b0;
         presc   <= PRESC_RST;
         msip    <= '0;
         mtip    <= '0;
         ready_r <= 1'b0;
         rdata_r <= '0;
         for (int h = 0; h < N_HARTS; h++) mtimecmp[h] <= MTIMECMP_RST;
      end else begin
         ready_r <= bus.valid;
         rdata_r <= rd ? rd_val : '0;

         for (int h = 0; h < N_HARTS; h++) mtip[h] <= (mtime >= mtimecmp[h]);

         // A bus write to either mtime word suppresses that cycle's increment.
         if (wr && sel_mtl) begin
            mtime[31:0] <= wr_val;
         end else if (wr && sel_mth) begin
            mtime[63:32] <= wr_val;
            shadow       <= wr_val;
         end else if (tick && en) begin
            mtime <= mtime + 64'd1;
         end

         if (rd && sel_mtl) shadow <= mtime[63:32];

         if (wr && sel_msip && bus.wstrb[0]) msip[msip_idx] <= bus.wdata[0];

         if (wr && sel_cmp) begin
            if (cmp_hi) mtimecmp[cmp_idx][63:32] <= wr_val;
            else        mtimecmp[cmp_idx][31:0]  <= wr_val;
         end

         if (ctrl_wr) begin
            en    <= ctrl_new[CTRL_EN_BIT];
            src   <= ctrl_new[CTRL_SRC_BIT];
            presc <= ctrl_new[CTRL_PRESC_LSB +: PRESC_W];
         end
      end
   end

   assign bus.ready = ready_r;
   assign bus.rdata = rdata_r;

endmodule

// File: tb/tb_iob_clint_mh.sv
`timescale 1ns/1ps
module tb_iob_clint_mh;

   localparam int N_HARTS = 2;
   localparam logic [15:0] A_CMP  = 16'h4000;
   localparam logic [15:0] A_CTRL = 16'hBFF0;
   localparam logic [15:0] A_MTL  = 16'hBFF8;
   localparam logic [15:0] A_MTH  = 16'hBFFC;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rtc = 1'b0;
   logic [N_HARTS-1:0] mtip, msip;

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   logic [63:0]        m_cmp [N_HARTS];
   logic [N_HARTS-1:0] m_msip;
   logic [63:0]        m_mtime;
   logic [31:0]        m_shadow;

   iob_clint_mh_if #(.ADDR_W(16), .DATA_W(32)) bus ();

   iob_clint_mh #(
      .N_HARTS(N_HARTS), .ADDR_W(16), .DATA_W(32), .SYNC_STAGES(2), .PRESC_RST(16'd0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rtc(rtc), .bus(bus.slave), .mtip(mtip), .msip(msip)
   );

   initial forever #5 clk = ~clk;
   initial forever #36.7 rtc = ~rtc;

   initial begin
      #3ms;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic bus_xfer(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [31:0] rdat);
      @(negedge clk);
      bus.valid = 1'b1; bus.address = a; bus.wdata = d; bus.wstrb = s;
      @(posedge clk); #1;
      bus.valid = 1'b0; bus.wstrb = 4'h0;
      check_val("ready_pulse", bus.ready, 1);
      rdat = bus.rdata;
      @(posedge clk); #1;
      check_val("ready_rdata_idle", {bus.ready, bus.rdata}, 0);
   endtask

   task automatic bw(input logic [15:0] a, input logic [31:0] d);
      logic [31:0] dummy;
      bus_xfer(a, d, 4'hF, dummy);
   endtask

   task automatic br(input logic [15:0] a, output logic [31:0] d);
      bus_xfer(a, 32'h0, 4'h0, d);
   endtask

   function automatic logic [31:0] byte_merge(input logic [31:0] o, input logic [31:0] n,
                                              input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
      return r;
   endfunction

   // CTRL is held at 0 throughout the randomized section, so it reads 0.
   function automatic logic [31:0] model_read(input logic [15:0] a);
      int ai;
      ai = int'(a);
      if (ai < 4 * N_HARTS) return {31'b0, m_msip[ai / 4]};
      if (ai >= 'h4000 && ai < 'h4000 + 8 * N_HARTS)
         return ai[2] ? m_cmp[(ai - 'h4000) / 8][63:32] : m_cmp[(ai - 'h4000) / 8][31:0];
      if (ai == 'hBFF8) return m_mtime[31:0];
      if (ai == 'hBFFC) return m_shadow;
      return 32'h0;
   endfunction

   function automatic void model_write(input logic [15:0] a, input logic [31:0] d,
                                       input logic [3:0] s);
      int ai, h;
      ai = int'(a);
      if (ai < 4 * N_HARTS) begin
         if (s[0]) m_msip[ai / 4] = d[0];
      end else if (ai >= 'h4000 && ai < 'h4000 + 8 * N_HARTS) begin
         h = (ai - 'h4000) / 8;
         if (ai[2]) m_cmp[h][63:32] = byte_merge(m_cmp[h][63:32], d, s);
         else       m_cmp[h][31:0]  = byte_merge(m_cmp[h][31:0], d, s);
      end else if (ai == 'hBFF8) begin
         m_mtime[31:0] = byte_merge(m_mtime[31:0], d, s);
      end else if (ai == 'hBFFC) begin
         m_mtime[63:32] = byte_merge(m_mtime[63:32], d, s);
         m_shadow = m_mtime[63:32];
      end
   endfunction

   initial begin
      logic [31:0] d, lo, hi, v1, v2, exp_rd;
      logic [15:0] a;
      logic [3:0]  s;
      logic [N_HARTS-1:0] exp_mtip;
      logic found;
      int kind;

      bus.valid = 1'b0; bus.address = '0; bus.wdata = '0; bus.wstrb = '0;

      // reset and idle
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_mtip", mtip, 0);
      check_val("rst_msip", msip, 0);
      check_val("rst_ready", bus.ready, 0);
      check_val("rst_rdata", bus.rdata, 0);
      @(negedge clk) rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check_val("idle_mtip", mtip, 0);
      check_val("idle_msip", msip, 0);
      br(A_CMP + 16'h8, d);
      check_val("cmp1_lo_rst", d, 32'hFFFF_FFFF);

      // rtc time base against two compare values
      bw(A_MTH, 0); bw(A_MTL, 0);
      bw(A_CMP + 16'h0, 200); bw(A_CMP + 16'h4, 0);
      bw(A_CMP + 16'h8, 400); bw(A_CMP + 16'hC, 0);
      found = 1'b0;
      for (int i = 0; i < 6000 && !found; i++) begin
         @(posedge clk); #1;
         if (mtip[0]) found = 1'b1;
      end
      check_val("mtip0_rise_seen", found, 1);
      check_val("mtip1_low_at_200", mtip[1], 0);
      br(A_MTL, d);
      check_val("mtime_at_mtip0", d, 200);
      found = 1'b0;
      for (int i = 0; i < 6000 && !found; i++) begin
         @(posedge clk); #1;
         if (mtip[1]) found = 1'b1;
      end
      check_val("mtip1_rise_seen", found, 1);
      br(A_MTL, d);
      check_val("mtime_at_mtip1", d, 400);
      bw(A_MTL, 0);
      check_val("mtip_clr_on_mtime0", mtip, 0);

      // prescaler, divide by 4
      bw(A_CTRL, 32'h0003_0003); bw(A_MTH, 0); bw(A_MTL, 0);
      repeat (38) @(posedge clk);
      br(A_MTL, d);
      check_val("presc3_count", (d >= 9 && d <= 11), 1);
      bw(A_CTRL, 32'h0003_0002);
      br(A_MTL, v1);
      repeat (40) @(posedge clk);
      br(A_MTL, v2);
      check_val("en0_frozen", v2, v1);

      // coherent 64-bit read across the low-word carry
      bw(A_MTH, 0); bw(A_MTL, 32'hFFFF_FFFE); bw(A_CTRL, 32'h0000_0003);
      for (int k = 0; k < 2; k++) begin
         br(A_MTL, lo); br(A_MTH, hi);
         if (k == 0) check_val("snap_near_carry", (lo - 32'hFFFF_FFFE) < 32'd8, 1);
         check_val("snap_hi", hi, (lo >= 32'h8000_0000) ? 32'd0 : 32'd1);
      end

      // wrap 2^64-1 -> 0 drops mtip
      bw(A_CTRL, 32'h0000_0002);
      bw(A_MTL, 32'hFFFF_FFFF); bw(A_MTH, 32'hFFFF_FFFF);
      bw(A_CMP + 16'h0, 5); bw(A_CMP + 16'h4, 0);
      check_val("mtip0_at_max", mtip[0], 1);
      bw(A_CTRL, 32'h0000_0003);
      @(posedge clk); #1;
      check_val("mtip0_after_wrap", mtip[0], 0);
      br(A_MTL, lo); br(A_MTH, hi);
      check_val("wrap_lo_small", lo < 32'd16, 1);
      check_val("wrap_hi_zero", hi, 0);

      // back-to-back reads
      @(negedge clk);
      bus.valid = 1'b1; bus.address = A_CTRL; bus.wstrb = 4'h0;
      @(posedge clk); #1;
      bus.address = A_CMP + 16'hC;
      check_val("b2b_ready0", bus.ready, 1);
      check_val("b2b_rdata0", bus.rdata, 32'h0000_0003);
      @(posedge clk); #1;
      bus.valid = 1'b0;
      check_val("b2b_ready1", bus.ready, 1);
      check_val("b2b_rdata1", bus.rdata, 0);
      @(posedge clk); #1;
      check_val("b2b_ready_end", bus.ready, 0);

      // MSIP
      bw(16'h0004, 32'hFFFF_FFFF);
      check_val("msip1_set", msip, 2'b10);
      br(16'h0004, d);
      check_val("msip1_read", d, 1);
      bw(16'h0004, 0);
      check_val("msip1_clr", msip, 0);
      bw(16'h0008, 32'hFFFF_FFFF);
      check_val("msip_oob_ignored", msip, 0);
      br(16'h0008, d);
      check_val("msip_oob_read", d, 0);

      // randomized register traffic against the model, mtime frozen
      bw(A_CTRL, 0);
      m_msip = '0;
      m_mtime = {$urandom, $urandom};
      bw(A_MTH, m_mtime[63:32]); bw(A_MTL, m_mtime[31:0]);
      m_shadow = m_mtime[63:32];
      for (int h = 0; h < N_HARTS; h++) begin
         m_cmp[h] = m_mtime + 64'($signed($urandom_range(0, 40)) - 20);
         bw(A_CMP + 16'(8 * h), m_cmp[h][31:0]);
         bw(A_CMP + 16'(8 * h + 4), m_cmp[h][63:32]);
      end
      for (int n = 0; n < 80; n++) begin
         kind = $urandom_range(0, 4);
         case (kind)
            0:       a = 16'(4 * $urandom_range(0, N_HARTS));
            1:       a = A_CMP + 16'(8 * $urandom_range(0, N_HARTS) + 4 * $urandom_range(0, 1));
            2:       a = A_MTL + 16'(4 * $urandom_range(0, 1));
            3:       a = A_CTRL;
            default: a = 16'hC000 + 16'(4 * $urandom_range(0, 1023));
         endcase
         d = $urandom;
         s = ($urandom_range(0, 1) == 1 || kind == 3) ? 4'h0 : 4'($urandom_range(1, 15));
         if (s == 4'h0) begin
            exp_rd = model_read(a);
            if (a == A_MTL) m_shadow = m_mtime[63:32];
         end else begin
            exp_rd = 32'h0;
            model_write(a, d, s);
         end
         bus_xfer(a, d, s, v1);
         check_val($sformatf("rand_rdata@%h", a), v1, exp_rd);
         check_val("rand_msip", msip, m_msip);
         for (int h = 0; h < N_HARTS; h++) exp_mtip[h] = (m_mtime >= m_cmp[h]);
         check_val("rand_mtip", mtip, exp_mtip);
      end

      // reset mid-transaction
      bw(A_CTRL, 32'h0000_0003);
      bw(A_CMP + 16'h0, 5); bw(A_CMP + 16'h4, 0);
      bw(A_MTH, 0); bw(A_MTL, 100);
      bw(16'h0000, 1);
      check_val("pre_rst_mtip0", mtip[0], 1);
      check_val("pre_rst_msip0", msip[0], 1);
      @(negedge clk);
      bus.valid = 1'b1; bus.address = A_MTL; bus.wstrb = 4'h0;
      #2 rst_n = 1'b0;
      #1;
      check_val("rst_now_mtip", mtip, 0);
      check_val("rst_now_msip", msip, 0);
      @(posedge clk); #1;
      check_val("rst_no_ready", bus.ready, 0);
      check_val("rst_no_rdata", bus.rdata, 0);
      @(negedge clk);
      bus.valid = 1'b0;
      rst_n = 1'b1;
      br(A_MTL, d);
      check_val("post_rst_mtime_small", d <= 32'd2, 1);
      br(A_CTRL, d);
      check_val("post_rst_ctrl", d, 32'h0000_0001);
      br(A_CMP, d);
      check_val("post_rst_cmp0", d, 32'hFFFF_FFFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/iob_clint_mh.md
Name: iob_clint_mh

Overview:
Parametrised multi-hart core-local interruptor, the next generation of the team's CLINT. It holds a 64-bit mtime counter plus one msip bit and one 64-bit mtimecmp per hart, and drives per-hart mtip/msip outputs. The time base is selectable at run time: either a synchronised external rtc, or an internal prescaled clk tick. Reading the low word of mtime snapshots the high word, so 64-bit reads are coherent. It sits on the native iob bus next to the CPU cores.

Parameters:
N_HARTS, 2, number of harts (1..16); one msip bit, one mtimecmp and one mtip/msip output bit each
ADDR_W, 16, bus byte-address width
DATA_W, 32, bus data width (fixed at 32)
SYNC_STAGES, 2, rtc synchroniser depth (>=2)
PRESC_RST, 16'd0, reset value of the prescaler divide field

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rtc  in  1  external real-time clock, asynchronous to clk
valid  in  1  bus request
address  in  ADDR_W  byte address, word aligned
wdata  in  DATA_W  write data
wstrb  in  DATA_W/8  byte enables; all-zero means read
rdata  out  DATA_W  read data, valid while ready=1
ready  out  1  one-cycle response pulse
mtip  out  N_HARTS  machine timer interrupt, one bit per hart
msip  out  N_HARTS  machine software interrupt, one bit per hart

Behaviour:
- Register map, 32-bit words:
  - MSIP[h] at 0x0000+4h: only bit0 is implemented; other bits read 0.
  - MTIMECMP[h] at 0x4000+8h (low word) and +4 (high word).
  - CTRL at 0xBFF0: bit0 EN, bit1 SRC (0=rtc, 1=prescaler), bits[31:16] PRESC.
  - MTIME at 0xBFF8 (low word) and 0xBFFC (high word).
- Unmapped addresses, and harts >= N_HARTS: reads return 0, writes are ignored, ready is still returned.
- Handshake: valid sampled at posedge. ready=1 exactly one cycle later, with rdata for that cycle; at all other times ready=0 and rdata=0. Back-to-back valid is accepted every cycle. wstrb applies per byte lane.
- Reset values, all asynchronous:
  - mtime=0; every mtimecmp=64'hFFFF_FFFF_FFFF_FFFF; msip=0; mtip=0.
  - CTRL: EN=1, SRC=0, PRESC=PRESC_RST.
  - ready=0; rdata=0; high-word snapshot=0; prescaler count=0; synchroniser flops=0.
- Tick, SRC=0: rtc passes through SYNC_STAGES flops; tick = one-cycle pulse on the synchronised rising edge. Latency from an rtc edge to tick is SYNC_STAGES+1 clk cycles.
- Tick, SRC=1: a down-counter reloads PRESC and pulses tick when it reaches 0, giving one tick every PRESC+1 clk cycles. PRESC=0 ticks every cycle.
- A CTRL write reloads the prescaler counter. Changing SRC discards any in-flight edge.
- mtime: increments by 1 on each tick while EN=1. It wraps 2^64-1 -> 0.
- Simultaneous bus write and tick: the bus write wins on the written bytes, and the increment is dropped for that cycle.
- mtip[h]: registered (mtime >= mtimecmp[h]), unsigned, updated every cycle. One cycle of latency after any mtime or mtimecmp change. After mtime wraps, mtip drops.
- msip[h]: equals MSIP[h].bit0 directly from the register.
- Snapshot: a read of MTIME low captures mtime[63:32] into the shadow register in the same cycle. A read of MTIME high returns the shadow, never the live value. Writes to MTIME high do update the shadow.
- Reset asserted mid-transaction: the response is abandoned and ready stays 0. The first valid after rst_n rises is serviced normally.

Decomposition:
- Package iob_clint_mh_pkg holds:
  - Offsets MSIP_BASE=0, MTIMECMP_BASE=16384, CTRL_ADDR=49136, MTIME_BASE=49144.
  - CTRL bit positions.
  - MTIME_W=64.
  - mtimecmp reset constant.
- One sub-module, iob_clint_mh_tick, contains the rtc synchroniser, edge detector, prescaler counter and SRC mux, with output tick. The top level holds the register file, the compare logic and the bus decode.

Test Plan:
- Reset, then idle 20 cycles with SRC=0 -> mtip=0 and msip=0. Read MTIMECMP[1] low gives 0xFFFFFFFF with ready exactly 1 cycle after valid.
- Write MTIMECMP[0]={0,200}, then MTIMECMP[1]={0,400}, using rtc ticks -> mtip[0] rises 1 cycle after mtime reaches 200 and mtip[1] stays 0 until 400. Writing MTIME=0 clears both bits within 2 cycles.
- Write CTRL = EN=1, SRC=1, PRESC=3; write MTIME=0; wait 40 cycles; read MTIME -> 10 (±1). Write EN=0, wait 40 cycles -> value unchanged.
- Write MTIME={0,0xFFFFFFFE} with PRESC=0 and read low then high across the carry -> the high word returned equals the snapshot taken at the low read, never a torn value. Write MTIME=all-ones -> wraps to 0, and mtip for MTIMECMP=5 deasserts.
- Write MSIP[1]=0xFFFFFFFF -> msip=2'b10 and the read returns 1. Write 0 -> msip=0. A write to MSIP[N_HARTS] is ignored and reads 0.
- Assert rst_n low mid-run with mtip=1 and valid=1 -> all outputs 0 immediately and ready is not produced. After release, the first read of MTIME returns a small value counted from 0.
